// File: rtl/fifo_rd_packer.sv
// Read-side drain for the async FIFO: pops narrow entries and packs PACK of them
// into one wide valid/ready word with a lane keep mask; a flush emits a partial word.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_rempty,
    input  logic [DATA_WIDTH-1:0]      i_rdata,
    output logic                       o_rinc,
    input  logic                       i_flush,
    output logic [DATA_WIDTH*PACK-1:0] o_m_data,
    output logic [PACK-1:0]            o_m_keep,
    output logic                       o_m_valid,
    input  logic                       i_m_ready,
    output logic                       o_busy
);

    localparam int CW = $clog2(PACK);
    localparam logic [CW-1:0] LAST = CW'(PACK - 1);

    logic [DATA_WIDTH-1:0]      acc [PACK-1];
    logic [CW-1:0]              acc_cnt;
    logic                       flush_pend;
    logic                       out_free;
    logic                       acc_last;
    logic [DATA_WIDTH*PACK-1:0] full_word;
    logic [DATA_WIDTH*PACK-1:0] part_word;
    logic [PACK-1:0]            part_keep;

    assign out_free = ~o_m_valid | i_m_ready;
    assign acc_last = (acc_cnt == LAST);
    assign o_rinc   = ~i_rst & ~i_rempty & ~flush_pend & (~acc_last | out_free);
    assign o_busy   = ~i_rst & ((acc_cnt != '0) | o_m_valid | flush_pend);

    // Candidate output words; lanes not yet filled stay zero in the partial word.
    always_comb begin
        full_word = '0;
        part_word = '0;
        part_keep = '0;
        for (int i = 0; i < PACK - 1; i++) begin
            full_word[i*DATA_WIDTH +: DATA_WIDTH] = acc[i];
            if (i < int'(acc_cnt)) begin
                part_word[i*DATA_WIDTH +: DATA_WIDTH] = acc[i];
                part_keep[i] = 1'b1;
            end
        end
        full_word[(PACK-1)*DATA_WIDTH +: DATA_WIDTH] = i_rdata;
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < PACK - 1; i++) begin
            if (o_rinc && !acc_last && acc_cnt == CW'(i)) begin
                acc[i] <= i_rdata;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_cnt    <= '0;
            flush_pend <= 1'b0;
            o_m_valid  <= 1'b0;
            o_m_data   <= '0;
            o_m_keep   <= '0;
        end else begin
            if (o_m_valid && i_m_ready) begin
                o_m_valid <= 1'b0;
            end
            if (o_rinc) begin
                if (acc_last) begin
                    o_m_data  <= full_word;
                    o_m_keep  <= '1;
                    o_m_valid <= 1'b1;
                    acc_cnt   <= '0;
                end else begin
                    acc_cnt <= acc_cnt + 1'b1;
                end
            end
            // Popping is blocked while flush_pend is set, so the two loads never collide.
            if (flush_pend) begin
                if (out_free) begin
                    flush_pend <= 1'b0;
                    if (acc_cnt != '0) begin
                        o_m_data  <= part_word;
                        o_m_keep  <= part_keep;
                        o_m_valid <= 1'b1;
                        acc_cnt   <= '0;
                    end
                end
            end else if (i_flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a FIFO model feeds directed bytes, a monitor
// compares every accepted word against expected words queued by the stimulus.
module tb_fifo_rd_packer;

    localparam int DW = 8;
    localparam int PK = 4;

    typedef struct packed {
        logic [DW*PK-1:0] data;
        logic [PK-1:0]    keep;
    } word_t;

    logic              clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_rempty = 1'b1;
    logic [DW-1:0]     i_rdata = '0;
    logic              o_rinc;
    logic              i_flush = 1'b0;
    logic [DW*PK-1:0]  o_m_data;
    logic [PK-1:0]     o_m_keep;
    logic              o_m_valid;
    logic              i_m_ready = 1'b0;
    logic              o_busy;

    logic [DW-1:0] fifo_q [$];
    word_t         exp_q [$];
    int            checks = 0;
    int            errors = 0;
    int            pops = 0;
    logic          tb_ready = 1'b1;
    logic          tb_gate = 1'b0;
    logic          tb_rst = 1'b0;
    logic          pop_now;

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_rempty(i_rempty), .i_rdata(i_rdata),
        .o_rinc(o_rinc), .i_flush(i_flush), .o_m_data(o_m_data), .o_m_keep(o_m_keep),
        .o_m_valid(o_m_valid), .i_m_ready(i_m_ready), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at negedge, latch pop decision, apply pop at posedge.
    task automatic cyc(input logic fl);
        @(negedge clk);
        i_rst     = tb_rst;
        i_flush   = fl;
        i_m_ready = tb_ready;
        i_rempty  = (fifo_q.size() == 0) || tb_gate;
        i_rdata   = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        #1;
        pop_now = o_rinc;
        @(posedge clk);
        if (pop_now && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        #1;
    endtask

    task automatic push_bytes(input logic [31:0] w);
        for (int i = 0; i < 4; i++) fifo_q.push_back(w[i*8 +: 8]);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
        word_t w;
        w.data = d;
        w.keep = k;
        exp_q.push_back(w);
    endtask

    task automatic drain(input string name);
        logic done;
        done = 1'b0;
        tb_ready = 1'b1;
        tb_gate  = 1'b0;
        for (int n = 0; n < 80 && !done; n++) begin
            cyc(1'b0);
            if (fifo_q.size() == 0 && !o_busy) done = 1'b1;
        end
        check(name, {31'b0, done}, 32'd1);
    endtask

    // Monitor: a word transfers on the coming edge when valid and ready are both high.
    always begin
        @(negedge clk);
        #2;
        if (i_rempty) check("rinc_while_empty", {31'b0, o_rinc}, 32'd0);
        if (o_m_valid && i_m_ready && !i_rst) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", o_m_data, 32'hFFFF_FFFF);
            end else begin
                word_t w;
                w = exp_q.pop_front();
                check("word_data", o_m_data, w.data);
                check("word_keep", {28'b0, o_m_keep}, {28'b0, w.keep});
            end
        end
    end

    initial begin
        // Reset state
        tb_rst = 1'b1;
        push_bytes(32'hEEEE_EEEE);
        cyc(1'b0);
        check("rst_rinc", {31'b0, o_rinc}, 32'd0);
        cyc(1'b0);
        check("rst_valid", {31'b0, o_m_valid}, 32'd0);
        check("rst_data", o_m_data, 32'd0);
        check("rst_keep", {28'b0, o_m_keep}, 32'd0);
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        check("rst_no_pop", pops, 0);
        fifo_q.delete();
        tb_rst = 1'b0;
        cyc(1'b0);

        // Basic packing with latency check
        pops = 0;
        push_bytes(32'h4433_2211);
        expect_word(32'h4433_2211, 4'hF);
        for (int i = 0; i < 4; i++) cyc(1'b0);
        check("t1_pops", pops, 4);
        check("t1_valid_after_4th", {31'b0, o_m_valid}, 32'd1);
        cyc(1'b0);
        check("t1_valid_one_cycle", {31'b0, o_m_valid}, 32'd0);
        drain("t1_drain");

        // Backpressure
        pops = 0;
        tb_ready = 1'b0;
        push_bytes(32'h0403_0201);
        push_bytes(32'h0807_0605);
        push_bytes(32'h0C0B_0A09);
        expect_word(32'h0403_0201, 4'hF);
        expect_word(32'h0807_0605, 4'hF);
        expect_word(32'h0C0B_0A09, 4'hF);
        for (int i = 0; i < 10; i++) cyc(1'b0);
        check("t2_pops_held", pops, 7);
        check("t2_rinc_low", {31'b0, o_rinc}, 32'd0);
        check("t2_rempty_low", {31'b0, i_rempty}, 32'd0);
        check("t2_data_held", o_m_data, 32'h0403_0201);
        check("t2_valid_held", {31'b0, o_m_valid}, 32'd1);
        tb_ready = 1'b1;
        cyc(1'b0);
        check("t2_back_to_back", o_m_data, 32'h0807_0605);
        drain("t2_drain");

        // Partial flush
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        expect_word(32'h0000_BBAA, 4'h3);
        for (int i = 0; i < 4; i++) cyc(1'b0);
        cyc(1'b1);
        check("t3_valid_edge1", {31'b0, o_m_valid}, 32'd0);
        check("t3_busy_pend", {31'b0, o_busy}, 32'd1);
        cyc(1'b0);
        check("t3_valid_edge2", {31'b0, o_m_valid}, 32'd1);
        check("t3_keep", {28'b0, o_m_keep}, 32'h3);
        cyc(1'b0);
        check("t3_busy_drop", {31'b0, o_busy}, 32'd0);

        // Flush with empty accumulator
        cyc(1'b1);
        check("t4_busy_pend", {31'b0, o_busy}, 32'd1);
        cyc(1'b0);
        check("t4_no_word", {31'b0, o_m_valid}, 32'd0);
        check("t4_pend_clear", {31'b0, o_busy}, 32'd0);

        // Flush coincident with the completing pop
        push_bytes(32'hA4A3_A2A1);
        expect_word(32'hA4A3_A2A1, 4'hF);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        check("t4_full_keep", {28'b0, o_m_keep}, 32'hF);
        for (int i = 0; i < 3; i++) cyc(1'b0);
        check("t4_no_partial", {31'b0, o_m_valid}, 32'd0);
        drain("t4_drain");

        // Reset mid-word
        pops = 0;
        fifo_q.push_back(8'h91);
        fifo_q.push_back(8'h92);
        fifo_q.push_back(8'h93);
        for (int i = 0; i < 3; i++) cyc(1'b0);
        check("t5_pops", pops, 3);
        push_bytes(32'h8877_6655);
        expect_word(32'h8877_6655, 4'hF);
        tb_rst = 1'b1;
        cyc(1'b0);
        check("t5_rst_rinc", {31'b0, pop_now}, 32'd0);
        check("t5_rst_valid", {31'b0, o_m_valid}, 32'd0);
        check("t5_rst_busy", {31'b0, o_busy}, 32'd0);
        tb_rst = 1'b0;
        drain("t5_drain");

        // Random empty gaps and backpressure
        for (int w = 0; w < 4; w++) begin
            logic [31:0] v;
            v = {8'(8'h33 + 4*w), 8'(8'h32 + 4*w), 8'(8'h31 + 4*w), 8'(8'h30 + 4*w)};
            push_bytes(v);
            expect_word(v, 4'hF);
        end
        for (int i = 0; i < 60; i++) begin
            tb_gate  = 1'($urandom_range(0, 1));
            tb_ready = 1'($urandom_range(0, 1));
            cyc(1'b0);
        end
        drain("t6_drain");

        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side drain stage for the asynchronous FIFO. Runs in the FIFO read-clock domain, pops DATA_WIDTH-bit entries through the FIFO's empty/increment handshake and packs PACK consecutive entries into one wide word. The wide word goes out on a valid/ready master port with a per-lane keep mask. A flush request emits a partially filled word, so trailing bytes never get stuck.

## Interface
- DATA_WIDTH, 8, width of one FIFO entry (must match the FIFO).
- PACK, 4, entries per output word; must be ≥2.
- i_clk  in  1  clock; the same clock that drives the FIFO read side.
- i_rst  in  1  synchronous, active-high reset.
- i_rempty  in  1  FIFO empty flag.
- i_rdata  in  DATA_WIDTH  FIFO read data; valid whenever i_rempty=0 (first-word fall-through).
- o_rinc  out  1  FIFO pop; an entry is consumed on each rising edge where o_rinc=1.
- i_flush  in  1  single-cycle request to emit the partial word.
- o_m_data  out  DATA_WIDTH*PACK  packed word; the first popped entry occupies lane 0 (LSBs).
- o_m_keep  out  PACK  lane-valid mask.
- o_m_valid  out  1  output word valid.
- i_m_ready  in  1  downstream accept.
- o_busy  out  1  high while the accumulator is non-empty, a word is pending, or a flush is pending.

## Operation
- State:
  - Accumulator `acc`: (PACK-1) lanes of DATA_WIDTH each.
  - `acc_cnt`: 0..PACK-1, width $clog2(PACK).
  - Output register: o_m_data, o_m_keep, o_m_valid.
  - `flush_pend` flag.
- `out_free` = ~o_m_valid | i_m_ready.
- o_rinc = ~i_rst & ~i_rempty & ~flush_pend & (acc_cnt < PACK-1 | out_free). This is combinational; it must never assert while i_rempty=1.
- Pop with acc_cnt < PACK-1: store i_rdata into lane acc_cnt, then acc_cnt += 1.
- Pop with acc_cnt == PACK-1 (completing pop):
  - o_m_data <= {i_rdata, acc}; o_m_keep <= all ones; o_m_valid <= 1.
  - acc_cnt <= 0.
- Output handshake:
  - A word transfers on any edge where o_m_valid & i_m_ready.
  - After a transfer, o_m_valid clears unless a new word is loaded in the same cycle.
  - o_m_data and o_m_keep stay stable while o_m_valid=1 and i_m_ready=0.
- Flush:
  - i_flush=1 sets flush_pend on the next edge. It is sticky, and repeat pulses are ignored.
  - While flush_pend=1, popping stops.
  - On the first cycle with flush_pend & out_free:
    - If acc_cnt > 0: load o_m_data with the acc lanes, upper lanes zero; o_m_keep = (1<<acc_cnt)-1; o_m_valid = 1; acc_cnt = 0.
    - If acc_cnt == 0: no word is emitted.
    - In both cases, flush_pend clears.
- i_flush in the same cycle as a pop: the pop completes and its entry is counted. The flush then applies to the resulting acc_cnt, including any word completed by that pop.
- Unused acc lanes are don't-care internally. Lanes with keep=0 on o_m_data must be driven to zero.

## Timing
- Reset (synchronous, i_rst=1 at an edge):
  - acc_cnt=0, flush_pend=0, o_m_valid=0, o_m_data=0, o_m_keep=0.
  - o_busy=0 and o_rinc=0 while i_rst=1.
- Reset mid-word: the partial accumulation is discarded. FIFO entries already popped are lost; this is the required behaviour.
- Latency: the word appears on o_m_valid one edge after the completing pop.
- Throughput: with continuous data and i_m_ready=1, one entry is popped every cycle and one word is produced every PACK cycles.
- Backpressure: with o_m_valid=1 and i_m_ready=0:
  - Popping continues until acc_cnt = PACK-1, then o_rinc=0.
  - Popping resumes in the cycle i_m_ready=1 (the completing pop and the output transfer share that edge).
- Flush latency: the partial word is valid two edges after the i_flush pulse when out_free holds.
- Empty gaps: acc_cnt holds its value indefinitely. No timeout exists.

## Test plan
- Pop 0x11,0x22,0x33,0x44 on consecutive cycles with i_m_ready=1 → o_m_data=0x44332211, keep=0xF, o_m_valid high for exactly one cycle, one edge after the 4th pop.
- Hold i_m_ready=0 and supply 12 entries (0x01..0x0C) → 7 pops, then o_rinc=0 with i_rempty=0. Word 0x04030201 is held stable. Releasing ready yields 0x04030201 followed by 0x08070605 one cycle later, then 0x0C0B0A09.
- Pop 0xAA,0xBB, then empty; pulse i_flush → o_m_data=0x0000BBAA, keep=0x3, two edges after the pulse; o_busy drops once the word is accepted.
- i_flush with acc_cnt=0 and no pending word → no o_m_valid; flush_pend clears next cycle. i_flush coincident with the 4th pop → one full word, keep=0xF, and no partial word.
- Assert i_rst after 3 pops, then pop 0x55,0x66,0x77,0x88 → output 0x88776655; o_rinc=0 and all outputs 0 during reset.
- Toggle i_rempty randomly → o_rinc is never high while i_rempty=1. Bench checks byte order against a scoreboard.
